// File: rtl/instr_decode_stage.sv
// RV32 instruction decode stage: decodes the raw word on entry, then buffers the
// decoded fields in a 2-entry skid FIFO with a valid/ready handshake on both sides.
module instr_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic [6:0]       funct7,
    output logic [2:0]       fmt,
    output logic [XLEN-1:0]  imm,
    output logic             illegal,
    output logic [CNT_W-1:0] decode_cnt
);

    localparam int unsigned DEPTH = 2;

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t      dec;
    entry_t      head;
    entry_t      mem [DEPTH];
    logic [31:0] imm32;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    // Decode of the incoming word; every immediate carries instruction[31] in bit 31.
    always_comb begin
        dec        = '0;
        imm32      = '0;
        dec.opcode = instruction[6:0];
        dec.rd     = instruction[11:7];
        dec.rs1    = instruction[19:15];
        dec.rs2    = instruction[24:20];
        dec.funct3 = instruction[14:12];
        dec.funct7 = instruction[31:25];
        dec.fmt    = FMT_ILL;
        case (instruction[6:0])
            7'b0110011: dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                dec.fmt = FMT_I;
                imm32   = {{20{instruction[31]}}, instruction[31:20]};
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                imm32   = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                imm32   = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                imm32   = {instruction[31:12], 12'h000};
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                imm32   = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
            end
            default: dec.fmt = FMT_ILL;
        endcase
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_ready  = (count < 2'(DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // FIFO storage, pointers, occupancy and consumed-entry counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            decode_cnt <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                decode_cnt <= decode_cnt + CNT_W'(1);
            end
            if (flush) begin
                count  <= 2'd0;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= dec;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // Present the head entry; all fields read zero while nothing is buffered.
    always_comb begin
        head = '0;
        if (out_valid) begin
            head = mem[rd_ptr];
        end
    end

    assign opcode  = head.opcode;
    assign rd      = head.rd;
    assign rs1     = head.rs1;
    assign rs2     = head.rs2;
    assign funct3  = head.funct3;
    assign funct7  = head.funct7;
    assign fmt     = head.fmt;
    assign imm     = head.imm;
    assign illegal = out_valid && (head.fmt == FMT_ILL);

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width (32 or 64 legal).
REQ-002 SHALL have parameter CNT_W, default 16, width of retired-decode counter.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, instruction word offered.
REQ-007 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-008 SHALL have port instruction, input, 32, raw RV32 instruction word.
REQ-009 SHALL have port out_valid, output, 1, decoded entry presented.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts entry this cycle.
REQ-011 SHALL have ports opcode/rd/rs1/rs2/funct3/funct7, outputs, 7/5/5/5/3/7, raw fields [6:0]/[11:7]/[19:15]/[24:20]/[14:12]/[31:25].
REQ-012 SHALL have port fmt, output, 3, format code: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal.
REQ-013 SHALL have port imm, output, XLEN, sign-extended immediate.
REQ-014 SHALL have port illegal, output, 1, high when fmt==7.
REQ-015 SHALL have port decode_cnt, output, CNT_W, count of entries consumed.

Function
REQ-016 Format by opcode: 0110011 R; 0010011/0000011/1100111/1110011/0001111 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J; any other (incl. [1:0]!=11) illegal.
REQ-017 imm: I sext(i[31:20]); S sext({i[31:25],i[11:7]}); B sext({i[31],i[7],i[30:25],i[11:8],0}); U sext({i[31:12],12'b0}); J sext({i[31],i[19:12],i[20],i[30:21],0}); R and illegal 0.
REQ-018 Sign extension SHALL replicate instruction bit 31 up to XLEN-1.
REQ-019 Decode SHALL be done before buffering; buffer stores decoded fields, not the raw word.
REQ-020 Buffer SHALL be a 2-entry FIFO (skid); push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-021 in_ready SHALL be registered-state-derived: high iff occupancy < 2; no combinational path from out_ready.
REQ-022 Latency: word pushed at edge N SHALL appear on outputs with out_valid=1 after edge N (cycle N+1) if buffer was empty.
REQ-023 out_valid SHALL equal occupancy != 0; outputs SHALL show head entry, held stable while out_valid & !out_ready.
REQ-024 Ordering SHALL be strict FIFO; simultaneous push and pop at occupancy 1 keeps occupancy 1, new entry becomes head next cycle.
REQ-025 Push with occupancy 2 impossible (in_ready=0); pop with occupancy 0 ignored.
REQ-026 decode_cnt SHALL increment by 1 per pop, wrapping modulo 2^CNT_W.
REQ-027 flush SHALL set occupancy 0 at next edge, dropping any same-cycle push and pop; a same-cycle pop still counts in decode_cnt.
REQ-028 Field outputs while out_valid=0 SHALL be zero.

Reset
REQ-029 rst_n low SHALL immediately clear occupancy, pointers, decode_cnt, all stored fields; out_valid=0, illegal=0, imm=0, fmt=0, in_ready=1 while in reset.
REQ-030 Reset mid-operation SHALL discard buffered entries; first edge after release accepts new words.

Verification
REQ-031 Push 0x00512423 (sw x5,8(x2)), out_ready=1 -> next cycle fmt=2, rs1=2, rs2=5, funct3=2, imm=0x00000008, illegal=0.
REQ-032 Push 0xFE112E23 (sw x1,-4(x2)) -> imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64).
REQ-033 Push 0xFE000CE3 (beq x0,x0,-8) -> fmt=3, imm=0xFFFFFFF8; push 0x00000000 -> fmt=7, illegal=1, imm=0.
REQ-034 out_ready=0, offer 3 words back-to-back -> in_ready low after 2 accepted, third held; raise out_ready -> outputs in order, decode_cnt=3.
REQ-035 Occupancy 2, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, pushed word absent.
REQ-036 Drop rst_n mid-stream with occupancy 1 -> out_valid=0, decode_cnt=0 immediately, before next clock edge.
